aes_cipher_iter: RTL and testbench

//  Iterative AES encryption core, one round per clock. Sits directly downstream of keyExpansion:

---
 rtl/aes_cipher_iter.sv | 183 ++++++++++++++++++
 tb/tb_aes_cipher_iter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter
//   Iterative AES encryption core, one round per clock. Consumes the flat
//   round-key schedule produced by keyExpansion and encrypts 128-bit blocks
//   under valid/ready handshakes. AES-128/192/256 via nk/nr.
// Parameters
//   nk        key length in 32-bit words (4, 6 or 8)
//   nb        block length in words (fixed at 4)
//   nr        round count (nk + 6)
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   w          round-key schedule, word i = w[32*i+31:32*i]
//   w_valid    one-cycle pulse: schedule on w complete and held stable
//   in_valid   plaintext offered
//   in_ready   core can accept plaintext (IDLE and key loaded)
//   data_in    plaintext, byte 0 = bits [127:120]
//   out_valid  ciphertext available
//   out_ready  downstream accepts ciphertext
//   data_out   ciphertext, same byte order as data_in
module aes_cipher_iter #(
    parameter int nk = 4,
    parameter int nb = 4,
    parameter int nr = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [32*nb*(nr+1)-1:0]   w,
    input  logic                      w_valid,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [127:0]              data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [127:0]              data_out
);

    localparam int RW = $clog2(nr + 1);

    if (nb != 4 || nr != nk + 6) begin : g_bad_cfg
        $error("aes_cipher_iter: unsupported nk/nb/nr combination");
    end

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes and ShiftRows fused: byte index i = 4*col + row; output
    // (row, col) takes the substituted input byte from (row, col+row mod 4).
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = SBOX[s[127-8*(4*((c+row)%4)+row) -: 8]];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    // Round key r = {word 4r, 4r+1, 4r+2, 4r+3}, word 4r in the top bits.
    logic [127:0] rk [nr+1];
    for (genvar r = 0; r <= nr; r++) begin : g_rk
        assign rk[r] = {w[128*r +: 32], w[128*r+32 +: 32],
                        w[128*r+64 +: 32], w[128*r+96 +: 32]};
    end

    state_e          state_q, state_d;
    logic            key_ok_q, key_ok_d;
    logic [RW-1:0]   round_q, round_d;
    logic [127:0]    st_q, st_d;
    logic [127:0]    data_out_q, data_out_d;
    logic            out_valid_q, out_valid_d;
    logic [127:0]    sub_shifted;
    logic [127:0]    mixed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_ok_q    <= 1'b0;
            round_q     <= '0;
            st_q        <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_ok_q    <= key_ok_d;
            round_q     <= round_d;
            st_q        <= st_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        in_ready    = (state_q == IDLE) && key_ok_q;
        sub_shifted = sub_shift(st_q);
        mixed       = mix_columns(sub_shifted);
        state_d     = state_q;
        key_ok_d    = key_ok_q | w_valid;
        round_d     = round_q;
        st_d        = st_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    st_d    = data_in ^ rk[0];
                    round_d = RW'(1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                // The final round (round_q == nr) skips MixColumns and
                // writes straight to the output register.
                if (round_q < RW'(nr)) begin
                    st_d    = mixed ^ rk[round_q];
                    round_d = round_q + RW'(1);
                end else begin
                    data_out_d  = sub_shifted ^ rk[round_q];
                    out_valid_d = 1'b1;
                    round_d     = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter
//   Directed FIPS-197 vectors against an AES-128 and an AES-256 instance.
//   The round-key schedules fed to the cores are built by a small key
//   expansion model in this bench; ciphertexts are the published values.
module tb_aes_cipher_iter;

    localparam logic [7:0] TB_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic           clk;
    logic           rst_n;

    logic [1407:0]  w_a;
    logic           w_valid_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [127:0]   data_in_a, data_out_a;

    logic [1919:0]  w_b;
    logic           w_valid_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [127:0]   data_in_b, data_out_b;

    int checks = 0;
    int passes = 0;

    aes_cipher_iter #(.nk(4), .nb(4), .nr(10)) u_aes128 (
        .clk(clk), .rst_n(rst_n), .w(w_a), .w_valid(w_valid_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .data_in(data_in_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .data_out(data_out_a)
    );

    aes_cipher_iter #(.nk(8), .nb(4), .nr(14)) u_aes256 (
        .clk(clk), .rst_n(rst_n), .w(w_b), .w_valid(w_valid_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .data_in(data_in_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .data_out(data_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {TB_SBOX[x[31:24]], TB_SBOX[x[23:16]], TB_SBOX[x[15:8]], TB_SBOX[x[7:0]]};
    endfunction

    // Key expansion model; key is left-aligned in 256 bits.
    function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]   wd [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] bus;
        bus = '0;
        rc  = 8'h01;
        for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = wd[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            wd[i] = wd[i-nk] ^ t;
        end
        for (int i = 0; i < 4*(nr+1); i++) bus[32*i +: 32] = wd[i];
        return bus;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key_a(input logic [127:0] key);
        logic [1919:0] full;
        full = expand_key({key, 128'h0}, 4, 10);
        w_a = full[1407:0];
        w_valid_a = 1'b1;
        tick();
        w_valid_a = 1'b0;
    endtask

    // Ticks until out_valid_a; cycles = -1 if the bound expires.
    task automatic wait_out_a(output int cycles);
        cycles = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (out_valid_a) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic drain_a();
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (out_valid_a !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid_a); else passes++;
        checks++; if (in_ready_a !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready_a); else passes++;
        checks++; if (data_out_a !== 128'h0) $display("FAIL reset_data_out got %h want 0", data_out_a); else passes++;
        checks++; if (in_ready_b !== 1'b0) $display("FAIL reset_in_ready_256 got %b want 0", in_ready_b); else passes++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_no_key();
        int lat;
        int bad;
        bad = 0;
        in_valid_a = 1'b1;
        data_in_a = PT_B;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (in_ready_a !== 1'b0 || out_valid_a !== 1'b0) bad++;
        end
        checks++; if (bad != 0) $display("FAIL nokey_idle bad_cycles got %0d want 0", bad); else passes++;
        load_key_a(KEY_B);
        checks++; if (in_ready_a !== 1'b1) $display("FAIL nokey_ready_after_key got %b want 1", in_ready_a); else passes++;
        tick();
        in_valid_a = 1'b0;
        checks++; if (in_ready_a !== 1'b0) $display("FAIL nokey_accept_next_edge in_ready got %b want 0", in_ready_a); else passes++;
        wait_out_a(lat);
        checks++; if (lat != 10) $display("FAIL nokey_latency got %0d want 10", lat); else passes++;
        checks++; if (data_out_a !== CT_B) $display("FAIL nokey_ct got %h want %h", data_out_a, CT_B); else passes++;
        drain_a();
    endtask

    task automatic test_fips_b();
        int lat;
        checks++; if (in_ready_a !== 1'b1) $display("FAIL fipsb_ready got %b want 1", in_ready_a); else passes++;
        in_valid_a = 1'b1;
        data_in_a = PT_B;
        tick();
        in_valid_a = 1'b0;
        wait_out_a(lat);
        checks++; if (lat != 10) $display("FAIL fipsb_latency got %0d want 10", lat); else passes++;
        checks++; if (data_out_a !== CT_B) $display("FAIL fipsb_ct got %h want %h", data_out_a, CT_B); else passes++;
        drain_a();
        checks++; if (out_valid_a !== 1'b0) $display("FAIL fipsb_out_valid_clear got %b want 0", out_valid_a); else passes++;
        checks++; if (in_ready_a !== 1'b1) $display("FAIL fipsb_ready_after_hs got %b want 1", in_ready_a); else passes++;
    endtask

    task automatic test_fips_c1();
        int lat;
        load_key_a(KEY_C1);
        in_valid_a = 1'b1;
        data_in_a = PT_C;
        tick();
        in_valid_a = 1'b0;
        wait_out_a(lat);
        checks++; if (lat != 10) $display("FAIL c1_latency got %0d want 10", lat); else passes++;
        checks++; if (data_out_a !== CT_C1) $display("FAIL c1_ct got %h want %h", data_out_a, CT_C1); else passes++;
        drain_a();
    endtask

    task automatic test_aes256();
        int lat;
        w_b = expand_key(KEY_C3, 8, 14);
        w_valid_b = 1'b1;
        tick();
        w_valid_b = 1'b0;
        in_valid_b = 1'b1;
        data_in_b = PT_C;
        tick();
        in_valid_b = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (out_valid_b) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat != 14) $display("FAIL c3_latency got %0d want 14", lat); else passes++;
        checks++; if (data_out_b !== CT_C3) $display("FAIL c3_ct got %h want %h", data_out_b, CT_C3); else passes++;
        out_ready_b = 1'b1;
        tick();
        out_ready_b = 1'b0;
        checks++; if (out_valid_b !== 1'b0) $display("FAIL c3_out_valid_clear got %b want 0", out_valid_b); else passes++;
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        in_valid_a = 1'b1;
        data_in_a = PT_C;
        tick();
        in_valid_a = 1'b0;
        wait_out_a(lat);
        checks++; if (lat != 10) $display("FAIL bp_latency got %0d want 10", lat); else passes++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid_a = (i == 4 || i == 11);
            data_in_a = PT_B;
            tick();
            if (out_valid_a !== 1'b1 || data_out_a !== CT_C1 || in_ready_a !== 1'b0) bad++;
        end
        in_valid_a = 1'b0;
        checks++; if (bad != 0) $display("FAIL bp_hold bad_cycles got %0d want 0", bad); else passes++;
        drain_a();
        checks++; if (in_ready_a !== 1'b1) $display("FAIL bp_ready_after_hs got %b want 1", in_ready_a); else passes++;
        in_valid_a = 1'b1;
        data_in_a = PT_C;
        tick();
        in_valid_a = 1'b0;
        checks++; if (in_ready_a !== 1'b0) $display("FAIL bp_reaccept in_ready got %b want 0", in_ready_a); else passes++;
        wait_out_a(lat);
        checks++; if (lat != 10 || data_out_a !== CT_C1) $display("FAIL bp_second_block lat %0d ct %h want 10 %h", lat, data_out_a, CT_C1); else passes++;
        drain_a();
    endtask

    task automatic test_reset_mid_round();
        int bad;
        in_valid_a = 1'b1;
        data_in_a = PT_C;
        tick();
        in_valid_a = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid_a !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid_a); else passes++;
        checks++; if (in_ready_a !== 1'b0) $display("FAIL midrst_in_ready got %b want 0", in_ready_a); else passes++;
        checks++; if (data_out_a !== 128'h0) $display("FAIL midrst_data_out got %h want 0", data_out_a); else passes++;
        tick();
        rst_n = 1'b1;
        in_valid_a = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (in_ready_a !== 1'b0 || out_valid_a !== 1'b0) bad++;
        end
        in_valid_a = 1'b0;
        checks++; if (bad != 0) $display("FAIL midrst_no_key bad_cycles got %0d want 0", bad); else passes++;
        load_key_a(KEY_C1);
        checks++; if (in_ready_a !== 1'b1) $display("FAIL midrst_ready_after_key got %b want 1", in_ready_a); else passes++;
    endtask

    initial begin
        rst_n = 1'b0;
        w_a = '0; w_valid_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0; data_in_a = '0;
        w_b = '0; w_valid_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; data_in_b = '0;
        test_reset();
        test_no_key();
        test_fips_b();
        test_fips_c1();
        test_aes256();
        test_backpressure();
        test_reset_mid_round();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
